// File: rtl/salsa20_pkg.sv
// Shared definitions for the Salsa20 block engine.
//   NUM_WORDS    : words in a Salsa20 state
//   QR_IDX       : word indices (y0,y1,y2,y3) for quarterround slots 0..7;
//                  slots 0..3 form the column round, slots 4..7 the row round
//   eng_state_t  : control FSM encoding of the block engine
//   params_legal : elaboration-time check of NUM_QR / ROUNDS
//   rotl32       : 32-bit rotate left
package salsa20_pkg;

    localparam int NUM_WORDS = 16;
    localparam int NUM_SLOTS = 8;

    localparam logic [3:0] QR_IDX [NUM_SLOTS][4] = '{
        '{4'd0,  4'd4,  4'd8,  4'd12},
        '{4'd5,  4'd9,  4'd13, 4'd1 },
        '{4'd10, 4'd14, 4'd2,  4'd6 },
        '{4'd15, 4'd3,  4'd7,  4'd11},
        '{4'd0,  4'd1,  4'd2,  4'd3 },
        '{4'd5,  4'd6,  4'd7,  4'd4 },
        '{4'd10, 4'd11, 4'd8,  4'd9 },
        '{4'd15, 4'd12, 4'd13, 4'd14}
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } eng_state_t;

    function automatic bit params_legal(input int num_qr, input int rounds);
        return ((num_qr == 1) || (num_qr == 2) || (num_qr == 4)) &&
               (rounds >= 2) && ((rounds % 2) == 0);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/salsa20_qr.sv
// Combinational Salsa20 quarterround.
//   y : input words, y[0]=y0 .. y[3]=y3
//   z : output words, z[0]=z0 .. z[3]=z3
module salsa20_qr
    import salsa20_pkg::*;
(
    input  logic [3:0][31:0] y,
    output logic [3:0][31:0] z
);

    logic [31:0] t0, t1, t2, t3;

    // Each step consumes the freshly updated word from the previous one.
    assign t1 = y[1] ^ rotl32(y[0] + y[3], 7);
    assign t2 = y[2] ^ rotl32(t1 + y[0], 9);
    assign t3 = y[3] ^ rotl32(t2 + t1, 13);
    assign t0 = y[0] ^ rotl32(t3 + t2, 18);

    assign z = {t3, t2, t1, t0};

endmodule

// File: rtl/salsa20_block_engine.sv
// Iterative Salsa20 block function with word-wise feed-forward add.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : begin a block; sampled only while ready=1
//   state_in  : 16-word input state, word i = state_in[32*i +: 32]
//   ready     : engine idle, a start will be accepted this cycle
//   valid     : state_out holds the result of the last accepted start
//   state_out : registered result, same word layout as state_in
// Handshake: a block is accepted on any rising edge where start=1 and
// ready=1. valid drops the cycle after acceptance and rises together with
// ready once the result is in state_out; it then holds until the next
// accepted start. start while ready=0 is dropped, never queued.
module salsa20_block_engine
    import salsa20_pkg::*;
#(
    parameter int NUM_QR = 1,
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] state_in,
    output logic         ready,
    output logic         valid,
    output logic [511:0] state_out
);

    localparam int NSTEP  = ROUNDS * 4 / NUM_QR;
    localparam int STEP_W = $clog2(NSTEP);

    if (!params_legal(NUM_QR, ROUNDS)) begin : g_param_check
        $error("salsa20_block_engine: NUM_QR must be 1, 2 or 4 and ROUNDS even and >= 2");
    end

    eng_state_t                       state_q, state_d;
    logic [STEP_W-1:0]                step_q, step_d;
    logic                             fin_q;
    logic                             valid_q;
    logic [NUM_WORDS-1:0][31:0]       x_q, in_q, x_round, sum;
    logic [511:0]                     state_out_q;
    logic                             accept;

    logic [2:0]                       q_sel [NUM_QR];
    logic [3:0][31:0]                 qr_y  [NUM_QR];
    logic [3:0][31:0]                 qr_z  [NUM_QR];

    // fin_q marks the cycle right after the result register is written;
    // ready/valid rise one edge later so the result sits in state_out first.
    assign ready     = (state_q == ST_IDLE) && !fin_q;
    assign valid     = valid_q;
    assign state_out = state_out_q;
    assign accept    = start && ready;

    // Slot for instance k at step s is (s*NUM_QR + k) mod 8; the 3-bit
    // truncation performs the mod. Slots issued together never share words.
    always_comb begin
        for (int k = 0; k < NUM_QR; k++) begin
            q_sel[k] = 3'((int'(step_q) * NUM_QR) + k);
            for (int j = 0; j < 4; j++) begin
                qr_y[k][j] = x_q[QR_IDX[q_sel[k]][j]];
            end
        end
    end

    for (genvar k = 0; k < NUM_QR; k++) begin : g_qr
        salsa20_qr u_qr (
            .y (qr_y[k]),
            .z (qr_z[k])
        );
    end

    always_comb begin
        x_round = x_q;
        for (int k = 0; k < NUM_QR; k++) begin
            for (int j = 0; j < 4; j++) begin
                x_round[QR_IDX[q_sel[k]][j]] = qr_z[k][j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            sum[i] = x_q[i] + in_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ROUND;
                    step_d  = '0;
                end
            end
            ST_ROUND: begin
                if (step_q == STEP_W'(NSTEP - 1)) begin
                    state_d = ST_FINAL;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + 1'b1;
                end
            end
            ST_FINAL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            fin_q       <= 1'b0;
            valid_q     <= 1'b0;
            x_q         <= '0;
            in_q        <= '0;
            state_out_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fin_q   <= (state_q == ST_FINAL);
            if (accept) begin
                x_q     <= state_in;
                in_q    <= state_in;
                valid_q <= 1'b0;
            end else if (state_q == ST_ROUND) begin
                x_q <= x_round;
            end
            if (state_q == ST_FINAL) begin
                state_out_q <= sum;
            end
            if (fin_q) begin
                valid_q <= 1'b1;
            end
        end
    end

endmodule
